matrix_output_arbiter: RTL and testbench
========================================

MATRIX_OUTPUT_ARBITER -- requirements
Module: matrix_output_arbiter

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of producer channels (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, matrix element width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, per-channel entries, power of two, minimum 2.
REQ-004 SHALL have port clk, input, 1, the single clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port resetn, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port in_matrix_en, input, NUM_CHANNELS, per-channel element strobe.
REQ-007 SHALL have port in_matrix, input, NUM_CHANNELS*DATA_WIDTH, packed elements, channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port in_end_row, input, NUM_CHANNELS, per-channel end-of-row strobe.
REQ-009 SHALL have port in_end, input, NUM_CHANNELS, per-channel end-of-matrix strobe.
REQ-010 SHALL have port out_valid, output, 1, output entry present.
REQ-011 SHALL have port out_ready, input, 1, sink accepts entry.
REQ-012 SHALL have port out_data, output, DATA_WIDTH, element value (zero for marker-only entries).
REQ-013 SHALL have port out_has_data, output, 1, entry carries an element.
REQ-014 SHALL have port out_end_row, output, 1, entry carries end-of-row.
REQ-015 SHALL have port out_end, output, 1, entry carries end-of-matrix.
REQ-016 SHALL have port out_channel, output, clog2(NUM_CHANNELS), source channel.
REQ-017 SHALL have port overflow, output, NUM_CHANNELS, sticky per-channel drop flag.

Function
REQ-018 SHALL push one entry {end, end_row, en, data} into channel c FIFO in any cycle where en|end_row|end of c is high; otherwise no push.
REQ-019 SHALL drop a push to a full FIFO and set overflow[c], unless that FIFO pops in the same cycle, in which case the push is accepted.
REQ-020 SHALL use FSM states ARB and XFER; reset state ARB.
REQ-021 In ARB, SHALL grant the first non-empty channel searching upward from last_grant+1 with wrap-around, pop its head into the output register, set out_valid, and go to XFER; stays in ARB when all FIFOs are empty.
REQ-022 In XFER, SHALL hold all out_* stable while out_valid && !out_ready; on out_valid && out_ready, SHALL return to ARB next cycle.
REQ-023 SHALL give latency of exactly 2 cycles from push (edge t) to out_valid (edge t+2) when idle and all FIFOs empty.
REQ-024 SHALL sustain one entry per 2 cycles with out_ready held high.
REQ-025 SHALL preserve per-channel entry order; no inter-channel ordering is guaranteed.

Reset
REQ-026 SHALL, while resetn low, clear all FIFO pointers, set out_valid, out_data, out_has_data, out_end_row, out_end, out_channel and overflow to 0, set last_grant to NUM_CHANNELS-1, state ARB.
REQ-027 SHALL discard an in-flight entry on reset assertion mid-XFER; no entry is replayed after release.

Configuration
REQ-028 SHALL support macro MATRIX_ARB_ROW_LOCK_EN.
REQ-029 With MATRIX_ARB_ROW_LOCK_EN defined, after granting channel c, ARB SHALL grant only c until an entry with end_row or end from c has been transferred, waiting in ARB while c is empty.
REQ-030 Without MATRIX_ARB_ROW_LOCK_EN, ARB SHALL re-arbitrate round-robin after every transferred entry.

Structure
REQ-031 SHALL place the entry struct typedef, FSM state enum and clog2-derived width constants in shared package matrix_output_pkg.
REQ-032 SHALL implement per-channel storage as sub-module matrix_out_fifo (synchronous FIFO with full/empty, instantiated NUM_CHANNELS times).

Verification
REQ-033 Single push ch2 data 0x1234, out_ready=1 -> out_valid at edge t+2, out_data 0x1234, out_channel 2, out_has_data 1.
REQ-034 Ch0 and ch1 push simultaneously every cycle for 4 cycles, no row lock -> output channel order 0,1,0,1,0,1,0,1 with per-channel data in push order.
REQ-035 Ch3 push 9 entries back-to-back with out_ready=0, FIFO_DEPTH 8 -> overflow[3]=1 after 9th, exactly 8 entries delivered once out_ready=1.
REQ-036 out_ready held 0 for 5 cycles mid-XFER -> out_* unchanged across all 5 cycles; single transfer on release.
REQ-037 With MATRIX_ARB_ROW_LOCK_EN, ch0 row of 3 elements + end_row interleaved with ch1 traffic -> 3 ch0 entries plus ch0 end_row entry contiguous before any ch1 entry.
REQ-038 resetn pulsed low during XFER with 3 entries queued -> all outputs 0 immediately; no output after release until new pushes.

Source files
------------

// File: rtl/matrix_output_pkg.sv
// Shared types and width helpers for the matrix output arbiter.
// Contents: FSM state enum, per-entry control struct, channel-index width helper.
// Macro MATRIX_ARB_ROW_LOCK_EN (used by matrix_output_arbiter) selects row-lock arbitration.
package matrix_output_pkg;

   localparam int unsigned DEF_NUM_CHANNELS = 4;
   localparam int unsigned DEF_DATA_WIDTH   = 32;
   localparam int unsigned DEF_FIFO_DEPTH   = 8;

   // Arbiter FSM: ARB picks a channel, XFER holds the entry until accepted
   typedef enum logic [0:0] {
      ARB  = 1'b0,
      XFER = 1'b1
   } arb_state_t;

   // Control flags stored with every FIFO entry, MSB first
   typedef struct packed {
      logic is_end;
      logic end_row;
      logic has_data;
   } entry_ctl_t;

   localparam int unsigned CTL_W = $bits(entry_ctl_t);

   // Channel index width; never narrower than one bit
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned DEF_CH_W = idx_width(DEF_NUM_CHANNELS);

endpackage

// File: rtl/matrix_output_arbiter_if.sv
// Bus bundle between matrix producers/sink and the output arbiter.
// Producer side: in_matrix_en/in_matrix/in_end_row/in_end (per channel).
// Sink side: out_valid/out_ready handshake with out_data, out_has_data,
// out_end_row, out_end, out_channel; overflow is the sticky drop flag.
// master = producers + sink (testbench/system), slave = arbiter.
interface matrix_output_arbiter_if
   import matrix_output_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS = DEF_NUM_CHANNELS,
   parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH
) ();

   localparam int unsigned CH_W = idx_width(NUM_CHANNELS);

   logic [NUM_CHANNELS-1:0]            in_matrix_en;
   logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_matrix;
   logic [NUM_CHANNELS-1:0]            in_end_row;
   logic [NUM_CHANNELS-1:0]            in_end;

   logic                               out_valid;
   logic                               out_ready;
   logic [DATA_WIDTH-1:0]              out_data;
   logic                               out_has_data;
   logic                               out_end_row;
   logic                               out_end;
   logic [CH_W-1:0]                    out_channel;
   logic [NUM_CHANNELS-1:0]            overflow;

   modport master (
      output in_matrix_en, in_matrix, in_end_row, in_end, out_ready,
      input  out_valid, out_data, out_has_data, out_end_row, out_end,
             out_channel, overflow
   );

   modport slave (
      input  in_matrix_en, in_matrix, in_end_row, in_end, out_ready,
      output out_valid, out_data, out_has_data, out_end_row, out_end,
             out_channel, overflow
   );

endinterface

// File: rtl/matrix_out_fifo.sv
// Per-channel synchronous FIFO with full/empty flags.
// Ports: clk, resetn (async active-low), i_push/i_push_data write side,
//        i_pop read side, o_head_c (combinational head), o_full_c, o_empty_c.
// A push while full is accepted only when a pop happens in the same cycle.
module matrix_out_fifo #(
   parameter int unsigned WIDTH = 35,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head_c,
   output logic             o_full_c,
   output logic             o_empty_c
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_pop;
   logic             w_push;

   // Extra pointer bit distinguishes full from empty
   assign o_empty_c = (r_wr_ptr == r_rd_ptr);
   assign o_full_c  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop     = i_pop & ~o_empty_c;
   assign w_push    = i_push & (~o_full_c | w_pop);
   assign o_head_c  = r_mem[r_rd_ptr[AW-1:0]];

   // Pointer update
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
   end

   // Storage needs no reset; pointers define validity
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
   end

endmodule

// File: rtl/matrix_output_arbiter.sv
// Merges NUM_CHANNELS matrix element streams into one valid/ready output.
// Ports: clk, resetn (async active-low), bus (matrix_output_arbiter_if.slave)
//        carrying per-channel strobes/data in and the single output stream.
// Each channel strobe is registered, then queued in its own matrix_out_fifo.
// A round-robin ARB/XFER FSM moves one entry per two cycles to the output.
// Macro MATRIX_ARB_ROW_LOCK_EN: once a channel is granted it keeps the grant
// until an entry carrying end_row or end from it has been transferred.
module matrix_output_arbiter
   import matrix_output_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS = DEF_NUM_CHANNELS,
   parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
   input logic                    clk,
   input logic                    resetn,
   matrix_output_arbiter_if.slave bus
);

   localparam int unsigned CH_W    = idx_width(NUM_CHANNELS);
   localparam int unsigned ENTRY_W = CTL_W + DATA_WIDTH;

   logic                    r_in_push  [NUM_CHANNELS];
   logic [ENTRY_W-1:0]      r_in_entry [NUM_CHANNELS];
   logic [ENTRY_W-1:0]      w_head     [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] w_full;
   logic [NUM_CHANNELS-1:0] w_empty;
   logic [NUM_CHANNELS-1:0] w_pop;
   logic [NUM_CHANNELS-1:0] w_drop;

   arb_state_t              r_state;
   logic [CH_W-1:0]         r_last_grant;
   logic                    r_out_valid;
   logic [DATA_WIDTH-1:0]   r_out_data;
   logic                    r_out_has_data;
   logic                    r_out_end_row;
   logic                    r_out_end;
   logic [CH_W-1:0]         r_out_channel;
   logic [NUM_CHANNELS-1:0] r_overflow;

`ifdef MATRIX_ARB_ROW_LOCK_EN
   logic                    r_locked;
   logic [CH_W-1:0]         r_lock_ch;
`endif

   logic                    w_rr_vld;
   logic [CH_W-1:0]         w_rr_ch;
   logic                    w_grant_vld;
   logic [CH_W-1:0]         w_grant_ch;
   logic [ENTRY_W-1:0]      w_sel;
   entry_ctl_t              w_sel_ctl;
   logic [DATA_WIDTH-1:0]   w_sel_data;

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : gen_ch
      // Input capture; marker-only entries carry zero data
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            r_in_push[c]  <= 1'b0;
            r_in_entry[c] <= '0;
         end else begin
            r_in_push[c]  <= bus.in_matrix_en[c] | bus.in_end_row[c] | bus.in_end[c];
            r_in_entry[c] <= {bus.in_end[c], bus.in_end_row[c], bus.in_matrix_en[c],
                              bus.in_matrix_en[c] ? bus.in_matrix[c*DATA_WIDTH +: DATA_WIDTH]
                                                  : DATA_WIDTH'(0)};
         end
      end

      matrix_out_fifo #(
         .WIDTH (ENTRY_W),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk         (clk),
         .resetn      (resetn),
         .i_push      (r_in_push[c]),
         .i_push_data (r_in_entry[c]),
         .i_pop       (w_pop[c]),
         .o_head_c    (w_head[c]),
         .o_full_c    (w_full[c]),
         .o_empty_c   (w_empty[c])
      );

      // A push into a full FIFO is lost unless that FIFO pops this cycle
      assign w_drop[c] = r_in_push[c] & w_full[c] & ~w_pop[c];
   end

   // Round-robin search upward from the channel after the last grant
   always_comb begin
      int unsigned idx;
      w_rr_vld = 1'b0;
      w_rr_ch  = '0;
      idx      = 0;
      for (int unsigned i = 1; i <= NUM_CHANNELS; i++) begin
         idx = 32'(r_last_grant) + i;
         if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
         if (!w_rr_vld && !w_empty[CH_W'(idx)]) begin
            w_rr_vld = 1'b1;
            w_rr_ch  = CH_W'(idx);
         end
      end
   end

`ifdef MATRIX_ARB_ROW_LOCK_EN
   // While locked only the locked channel may be granted, even if empty
   assign w_grant_vld = r_locked ? ~w_empty[r_lock_ch] : w_rr_vld;
   assign w_grant_ch  = r_locked ? r_lock_ch : w_rr_ch;
`else
   assign w_grant_vld = w_rr_vld;
   assign w_grant_ch  = w_rr_ch;
`endif

   assign w_pop      = (r_state == ARB && w_grant_vld) ? (NUM_CHANNELS'(1) << w_grant_ch)
                                                       : '0;
   assign w_sel      = w_head[w_grant_ch];
   assign w_sel_ctl  = entry_ctl_t'(w_sel[ENTRY_W-1 -: CTL_W]);
   assign w_sel_data = w_sel[DATA_WIDTH-1:0];

   // Arbiter FSM with registered output stage
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state        <= ARB;
         r_last_grant   <= CH_W'(NUM_CHANNELS - 1);
         r_out_valid    <= 1'b0;
         r_out_data     <= '0;
         r_out_has_data <= 1'b0;
         r_out_end_row  <= 1'b0;
         r_out_end      <= 1'b0;
         r_out_channel  <= '0;
         r_overflow     <= '0;
`ifdef MATRIX_ARB_ROW_LOCK_EN
         r_locked       <= 1'b0;
         r_lock_ch      <= '0;
`endif
      end else begin
         r_overflow <= r_overflow | w_drop;
         case (r_state)
            ARB: begin
               if (w_grant_vld) begin
                  r_out_valid    <= 1'b1;
                  r_out_data     <= w_sel_data;
                  r_out_has_data <= w_sel_ctl.has_data;
                  r_out_end_row  <= w_sel_ctl.end_row;
                  r_out_end      <= w_sel_ctl.is_end;
                  r_out_channel  <= w_grant_ch;
                  r_last_grant   <= w_grant_ch;
`ifdef MATRIX_ARB_ROW_LOCK_EN
                  // XFER only exits on transfer, so the lock can be set at pop time
                  r_locked       <= ~(w_sel_ctl.end_row | w_sel_ctl.is_end);
                  r_lock_ch      <= w_grant_ch;
`endif
                  r_state        <= XFER;
               end
            end
            XFER: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ARB;
               end
            end
            default: r_state <= ARB;
         endcase
      end
   end

   assign bus.out_valid    = r_out_valid;
   assign bus.out_data     = r_out_data;
   assign bus.out_has_data = r_out_has_data;
   assign bus.out_end_row  = r_out_end_row;
   assign bus.out_end      = r_out_end;
   assign bus.out_channel  = r_out_channel;
   assign bus.overflow     = r_overflow;

endmodule

// File: tb/tb_matrix_output_arbiter.sv
// Self-checking bench for matrix_output_arbiter (default parameters).
// Build with MATRIX_ARB_ROW_LOCK_EN defined to exercise the row-lock sequence
// instead of the round-robin interleave sequence.
module tb_matrix_output_arbiter;
   import matrix_output_pkg::*;

   localparam int unsigned NCH = 4;
   localparam int unsigned DW  = 32;
   localparam int unsigned FD  = 8;

   logic clk = 1'b0;
   logic resetn;

   always #5 clk = ~clk;

   matrix_output_arbiter_if #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW)) bus ();

   matrix_output_arbiter #(
      .NUM_CHANNELS (NCH),
      .DATA_WIDTH   (DW),
      .FIFO_DEPTH   (FD)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   typedef struct {
      int          ch;
      logic [31:0] data;
      logic        has_data;
      logic        end_row;
      logic        is_end;
   } exp_t;

   typedef struct {
      int          ch;
      logic        en;
      logic        er;
      logic        e;
      logic [31:0] din;
      logic        exp_valid;
      logic [31:0] exp_data;
      logic        exp_has;
      logic        exp_er;
      logic        exp_e;
   } vec_t;

   exp_t sb[$];
   int   order_q[$];
   vec_t vecs[7];
   int   total  = 0;
   int   bad    = 0;
   int   n_xfer = 0;
   int   n0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard check of one accepted output entry
   task automatic mon_xfer();
      int   ch;
      int   idx;
      exp_t e;
      ch  = int'(bus.out_channel);
      idx = -1;
      foreach (sb[i]) if (idx < 0 && sb[i].ch == ch) idx = i;
      if (order_q.size() > 0) chk("order_channel", 64'(ch), 64'(order_q.pop_front()));
      chk($sformatf("sb_entry_for_ch%0d", ch), 64'(idx >= 0), 64'd1);
      if (idx >= 0) begin
         e = sb[idx];
         sb.delete(idx);
         chk("sb_data",     64'(bus.out_data),     64'(e.data));
         chk("sb_has_data", 64'(bus.out_has_data), 64'(e.has_data));
         chk("sb_end_row",  64'(bus.out_end_row),  64'(e.end_row));
         chk("sb_end",      64'(bus.out_end),      64'(e.is_end));
      end
   endtask

   // Inputs change just after posedge, so negedge shows the upcoming handshake
   always @(negedge clk) begin
      if (resetn === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         n_xfer++;
         mon_xfer();
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      bus.in_matrix_en = '0;
      bus.in_matrix    = '0;
      bus.in_end_row   = '0;
      bus.in_end       = '0;
   endtask

   task automatic push_ch(input int ch, input logic en, input logic er, input logic e,
                          input logic [31:0] d, input bit expect_out);
      bus.in_matrix_en[ch]     = en;
      bus.in_end_row[ch]       = er;
      bus.in_end[ch]           = e;
      bus.in_matrix[ch*DW +: DW] = d;
      if (expect_out && (en | er | e)) sb.push_back('{ch, en ? d : 32'h0, en, er, e});
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         step();
         n++;
      end
      step();
      step();
      chk({name, "_drained"}, 64'(sb.size()), 64'd0);
   endtask

   task automatic do_reset();
      resetn        = 1'b0;
      clr_in();
      bus.out_ready = 1'b1;
      sb.delete();
      order_q.delete();
      step();
      step();
      resetn = 1'b1;
      step();
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_valid"},    64'(bus.out_valid),    64'd0);
      chk({name, "_data"},     64'(bus.out_data),     64'd0);
      chk({name, "_has_data"}, 64'(bus.out_has_data), 64'd0);
      chk({name, "_end_row"},  64'(bus.out_end_row),  64'd0);
      chk({name, "_end"},      64'(bus.out_end),      64'd0);
      chk({name, "_channel"},  64'(bus.out_channel),  64'd0);
      chk({name, "_overflow"}, 64'(bus.overflow),     64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //            ch en er e  din            vld data           has er e
      vecs[0] = '{2, 1, 0, 0, 32'h0000_1234, 1, 32'h0000_1234, 1, 0, 0};
      vecs[1] = '{0, 0, 1, 0, 32'hDEAD_BEEF, 1, 32'h0000_0000, 0, 1, 0};
      vecs[2] = '{3, 0, 0, 1, 32'h0000_0055, 1, 32'h0000_0000, 0, 0, 1};
      vecs[3] = '{1, 1, 1, 0, 32'hA5A5_A5A5, 1, 32'hA5A5_A5A5, 1, 1, 0};
      vecs[4] = '{0, 1, 0, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1, 0, 1};
      vecs[5] = '{3, 1, 1, 1, 32'h0BAD_F00D, 1, 32'h0BAD_F00D, 1, 1, 1};
      vecs[6] = '{1, 0, 0, 0, 32'h0000_0777, 0, 32'h0000_0000, 0, 0, 0};

      resetn        = 1'b0;
      bus.out_ready = 1'b1;
      clr_in();
      step();
      step();
      chk_all_zero("reset");
      resetn = 1'b1;
      step();

      // Single pushes: latency, field packing, marker-only zero data
      foreach (vecs[k]) begin
         push_ch(vecs[k].ch, vecs[k].en, vecs[k].er, vecs[k].e, vecs[k].din, 1'b1);
         step();
         clr_in();
         chk($sformatf("v%0d_valid_t0", k), 64'(bus.out_valid), 64'd0);
         step();
         chk($sformatf("v%0d_valid_t1", k), 64'(bus.out_valid), 64'd0);
         step();
         chk($sformatf("v%0d_valid_t2", k), 64'(bus.out_valid), 64'(vecs[k].exp_valid));
         if (vecs[k].exp_valid) begin
            chk($sformatf("v%0d_data", k),     64'(bus.out_data),     64'(vecs[k].exp_data));
            chk($sformatf("v%0d_has_data", k), 64'(bus.out_has_data), 64'(vecs[k].exp_has));
            chk($sformatf("v%0d_end_row", k),  64'(bus.out_end_row),  64'(vecs[k].exp_er));
            chk($sformatf("v%0d_end", k),      64'(bus.out_end),      64'(vecs[k].exp_e));
            chk($sformatf("v%0d_channel", k),  64'(bus.out_channel),  64'(vecs[k].ch));
         end
         drain($sformatf("v%0d", k));
      end

`ifndef MATRIX_ARB_ROW_LOCK_EN
      // Two channels pushing together alternate 0,1,0,1,...
      do_reset();
      order_q = '{0, 1, 0, 1, 0, 1, 0, 1};
      for (int k = 0; k < 4; k++) begin
         push_ch(0, 1'b1, 1'b0, 1'b0, 32'h100 + 32'(k), 1'b1);
         push_ch(1, 1'b1, 1'b0, 1'b0, 32'h200 + 32'(k), 1'b1);
         step();
      end
      clr_in();
      drain("rr");
      chk("rr_order_consumed", 64'(order_q.size()), 64'd0);
`else
      // Row lock: ch0 row plus end_row stays contiguous ahead of ch1
      do_reset();
      order_q = '{0, 0, 0, 0, 1, 1, 1};
      push_ch(0, 1'b1, 1'b0, 1'b0, 32'hA0, 1'b1);
      push_ch(1, 1'b1, 1'b0, 1'b0, 32'hB0, 1'b1);
      step();
      push_ch(0, 1'b1, 1'b0, 1'b0, 32'hA1, 1'b1);
      push_ch(1, 1'b1, 1'b0, 1'b0, 32'hB1, 1'b1);
      step();
      push_ch(0, 1'b1, 1'b0, 1'b0, 32'hA2, 1'b1);
      push_ch(1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1);
      step();
      push_ch(0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1);
      push_ch(1, 1'b1, 1'b0, 1'b0, 32'hB2, 1'b1);
      step();
      clr_in();
      drain("lock");
      chk("lock_order_consumed", 64'(order_q.size()), 64'd0);
`endif

      // Overflow: output register busy, ch3 burst of 9 into an 8-deep FIFO
      do_reset();
      bus.out_ready = 1'b0;
      push_ch(2, 1'b1, 1'b0, 1'b0, 32'hC2, 1'b1);
      step();
      clr_in();
      step();
      step();
      chk("ovf_hold_valid",   64'(bus.out_valid),   64'd1);
      chk("ovf_hold_channel", 64'(bus.out_channel), 64'd2);
      for (int k = 0; k < 9; k++) begin
         push_ch(3, 1'b1, 1'b0, 1'b0, 32'h300 + 32'(k), k < 8);
         step();
      end
      clr_in();
      chk("ovf_after_8", 64'(bus.overflow), 64'h0);
      step();
      chk("ovf_after_9", 64'(bus.overflow), 64'h8);
      n0 = n_xfer;
      bus.out_ready = 1'b1;
      drain("ovf");
      chk("ovf_delivered", 64'(n_xfer - n0), 64'd9);
      chk("ovf_sticky",    64'(bus.overflow), 64'h8);

      // Back-pressure: outputs held for 5 stalled cycles, one transfer on release
      do_reset();
      bus.out_ready = 1'b0;
      push_ch(1, 1'b1, 1'b0, 1'b0, 32'hCAFE_0001, 1'b1);
      step();
      clr_in();
      step();
      step();
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("stall%0d_valid", k),   64'(bus.out_valid),    64'd1);
         chk($sformatf("stall%0d_data", k),    64'(bus.out_data),     64'hCAFE_0001);
         chk($sformatf("stall%0d_channel", k), 64'(bus.out_channel),  64'd1);
         chk($sformatf("stall%0d_has", k),     64'(bus.out_has_data), 64'd1);
         step();
      end
      n0 = n_xfer;
      bus.out_ready = 1'b1;
      step();
      chk("stall_release_one", 64'(n_xfer - n0), 64'd1);
      step();
      step();
      chk("stall_release_only_one", 64'(n_xfer - n0), 64'd1);
      chk("stall_valid_low",        64'(bus.out_valid), 64'd0);

      // Reset mid-XFER with entries queued: nothing replayed afterwards
      do_reset();
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         push_ch(0, 1'b1, 1'b0, 1'b0, 32'h400 + 32'(k), 1'b1);
         step();
      end
      clr_in();
      chk("rst_mid_valid_before", 64'(bus.out_valid), 64'd1);
      @(negedge clk);
      resetn = 1'b0;
      sb.delete();
      #1;
      chk_all_zero("rst_mid");
      step();
      step();
      resetn        = 1'b1;
      bus.out_ready = 1'b1;
      n0 = n_xfer;
      repeat (10) step();
      chk("rst_no_replay",  64'(n_xfer - n0), 64'd0);
      chk("rst_valid_low",  64'(bus.out_valid), 64'd0);
      push_ch(2, 1'b1, 1'b0, 1'b0, 32'hBEEF, 1'b1);
      step();
      clr_in();
      step();
      step();
      chk("rst_new_valid", 64'(bus.out_valid), 64'd1);
      chk("rst_new_data",  64'(bus.out_data),  64'hBEEF);
      drain("rst_new");

      chk("final_sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
